// File: rtl/clint_tick_agent.sv
// APB4 requester that arms CLINT mtimecmp for a drift-free periodic tick and clears MSIP.
// Define CLINT_TICK_AGENT_CNT_EN to add the 32-bit tick counter output tick_cnt_o.
module clint_tick_agent #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned SETTLE    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [31:0] period_i,
  input  logic        tmr_irq_i,
  input  logic        sfr_irq_i,
  output logic        tick_o,
  output logic        sfr_ack_o,
  output logic        busy_o,
  output logic        err_o,
`ifdef CLINT_TICK_AGENT_CNT_EN
  output logic [31:0] tick_cnt_o,
`endif
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  localparam logic [31:0] OffMsip  = 32'h00;
  localparam logic [31:0] OffMtL   = 32'h04;
  localparam logic [31:0] OffMtH   = 32'h08;
  localparam logic [31:0] OffCmpL  = 32'h0C;
  localparam logic [31:0] OffCmpH  = 32'h10;
  localparam int unsigned CntW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [3:0] {
    StIdle, StRdH1, StRdL, StRdH2, StWrClMax, StWrCh, StWrCl, StSettle, StWait, StClrMsip
  } state_e;

  state_e            state_q, state_d, ret_q, ret_d;
  logic              phase_q, phase_d;
  logic              en_q;
  logic              err_q, err_d;
  logic [31:0]       h1_q, h1_d, l_q, l_d, period_q, period_d;
  logic [63:0]       cmp_q, cmp_d;
  logic [CntW-1:0]   settle_q, settle_d;
  logic [31:0]       period_eff;
  logic              arm, done;

  assign period_eff = (period_i == '0) ? 32'd1 : period_i;
  assign arm        = (state_q == StIdle) && en_i && !en_q;
  assign done       = psel_o && penable_o && pready_i;
  assign busy_o     = (state_q != StIdle) && (state_q != StWait);
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      ret_q    <= StIdle;
      phase_q  <= 1'b0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      h1_q     <= '0;
      l_q      <= '0;
      period_q <= '0;
      cmp_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      phase_q  <= phase_d;
      en_q     <= en_i;
      err_q    <= err_d;
      h1_q     <= h1_d;
      l_q      <= l_d;
      period_q <= period_d;
      cmp_q    <= cmp_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    phase_d   = phase_q;
    err_d     = err_q;
    h1_d      = h1_q;
    l_d       = l_q;
    period_d  = period_q;
    cmp_d     = cmp_q;
    settle_d  = settle_q;
    tick_o    = 1'b0;
    sfr_ack_o = 1'b0;
    if (!en_i) err_d = 1'b0;
    if (psel_o) phase_d = !phase_q ? 1'b1 : !pready_i;

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d  = StRdH1;
          period_d = period_eff;
        end else if (en_i && !err_q && sfr_irq_i) begin
          ret_d   = StIdle;
          state_d = StClrMsip;
        end
      end
      StRdH1: if (done) begin
        h1_d    = prdata_i;
        state_d = StRdL;
      end
      StRdL: if (done) begin
        l_d     = prdata_i;
        state_d = StRdH2;
      end
      StRdH2: if (done) begin
        // A changed high word means the low word carried between reads.
        if (prdata_i != h1_q) begin
          state_d = StRdH1;
        end else begin
          cmp_d   = {h1_q, l_q} + {32'h0, period_q};
          state_d = StWrClMax;
        end
      end
      StWrClMax: if (done) state_d = StWrCh;
      StWrCh:    if (done) state_d = StWrCl;
      StWrCl: if (done) begin
        settle_d = '0;
        state_d  = (SETTLE == 0) ? StWait : StSettle;
      end
      StSettle: begin
        if (!en_i) state_d = StIdle;
        else if (settle_q == CntW'(SETTLE - 1)) state_d = StWait;
        else settle_d = settle_q + 1'b1;
      end
      StWait: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (sfr_irq_i) begin
          ret_d   = StWait;
          state_d = StClrMsip;
        end else if (tmr_irq_i) begin
          tick_o  = 1'b1;
          cmp_d   = cmp_q + {32'h0, period_eff};
          state_d = StWrClMax;
        end
      end
      StClrMsip: if (done) begin
        sfr_ack_o = !pslverr_i;
        state_d   = ret_q;
      end
      default: state_d = StIdle;
    endcase

    // Errors and disable both end the sequence once the in-flight transfer completes.
    if (done && (pslverr_i || !en_i)) state_d = StIdle;
    if (done && pslverr_i) err_d = 1'b1;
  end

  always_comb begin
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    pstrb_o   = '0;
    case (state_q)
      StRdH1, StRdH2: begin
        psel_o  = 1'b1;
        paddr_o = BASE_ADDR + OffMtH;
      end
      StRdL: begin
        psel_o  = 1'b1;
        paddr_o = BASE_ADDR + OffMtL;
      end
      StWrClMax, StWrCh, StWrCl, StClrMsip: begin
        psel_o   = 1'b1;
        pwrite_o = 1'b1;
        pstrb_o  = 4'hF;
        unique case (state_q)
          StWrClMax: begin
            paddr_o  = BASE_ADDR + OffCmpL;
            pwdata_o = 32'hFFFF_FFFF;
          end
          StWrCh: begin
            paddr_o  = BASE_ADDR + OffCmpH;
            pwdata_o = cmp_q[63:32];
          end
          StWrCl: begin
            paddr_o  = BASE_ADDR + OffCmpL;
            pwdata_o = cmp_q[31:0];
          end
          default: paddr_o = BASE_ADDR + OffMsip;
        endcase
      end
      default: ;
    endcase
    penable_o = psel_o && phase_q;
  end

`ifdef CLINT_TICK_AGENT_CNT_EN
  logic [31:0] tick_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    tick_cnt_q <= '0;
    else if (arm)    tick_cnt_q <= '0;
    else if (tick_o) tick_cnt_q <= tick_cnt_q + 32'd1;
  end

  assign tick_cnt_o = tick_cnt_q;
`else
  // Tick counter not built.
`endif

endmodule

// File: tb/tb_clint_tick_agent.sv
// Directed bench for clint_tick_agent with a behavioural CLINT APB responder.
module tb_clint_tick_agent;
  localparam logic [31:0] Base = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, tmr = 1'b0, sfr = 1'b0;
  logic [31:0] period = '0;
  logic tick, sfr_ack, busy, err;
  logic [31:0] paddr, pwdata, prdata;
  logic psel, penable, pwrite, pready, pslverr;
  logic [3:0] pstrb;
`ifdef CLINT_TICK_AGENT_CNT_EN
  logic [31:0] tick_cnt;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  clint_tick_agent dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .period_i(period),
    .tmr_irq_i(tmr), .sfr_irq_i(sfr), .tick_o(tick), .sfr_ack_o(sfr_ack),
    .busy_o(busy), .err_o(err),
`ifdef CLINT_TICK_AGENT_CNT_EN
    .tick_cnt_o(tick_cnt),
`endif
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  // Responder model.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
    int unsigned cyc;
  } wr_t;
  wr_t wlog[$];

  int unsigned wait_n = 0;
  logic        err_inject = 1'b0;
  logic [31:0] err_addr = '0;
  logic        carry_mode = 1'b0;
  int unsigned carry_base = 0;
  logic [63:0] mtime = '0;
  logic [63:0] mtime_eff;
  int unsigned lreads = 0, hreads = 0, wcnt = 0, cyc = 0, ticks = 0, acks = 0, last_tick = 0;

  assign mtime_eff = (carry_mode && lreads != carry_base) ? mtime + 64'h20 : mtime;
  assign pready    = psel && penable && (wcnt >= wait_n);
  assign pslverr   = pready && err_inject && (paddr == err_addr);

  always_comb begin
    prdata = '0;
    if (paddr == Base + 32'h4) prdata = mtime_eff[31:0];
    if (paddr == Base + 32'h8) prdata = mtime_eff[63:32];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wcnt <= (psel && penable && !pready) ? wcnt + 1 : 0;
    if (psel && penable && pready) begin
      if (pwrite) wlog.push_back('{paddr, pwdata, pstrb, pslverr, cyc});
      else if (paddr == Base + 32'h4) lreads <= lreads + 1;
      else if (paddr == Base + 32'h8) hreads <= hreads + 1;
    end
    if (tick) begin
      ticks <= ticks + 1;
      last_tick <= cyc;
    end
    if (sfr_ack) acks <= acks + 1;
  end

  function automatic logic [67:0] went(input int i);
    if (i < wlog.size()) return {wlog[i].strb, wlog[i].addr, wlog[i].data};
    return 'x;
  endfunction

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wlog.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic arm(input logic [63:0] mt, input logic [31:0] per, output bit ok);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    mtime = mt;
    period = per;
    wlog.delete();
    en = 1'b1;
    wait_writes(3, 200, ok);
    if (ok) wait_idle(50, ok);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tick, sfr_ack, busy, err, psel, penable, pwrite, pstrb} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {tick, sfr_ack, busy, err, psel, penable, pwrite, pstrb});
    end
    checks++;
    if ({paddr, pwdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0", {paddr, pwdata});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, psel} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got %b want 00", {busy, psel});
    end
`ifdef CLINT_TICK_AGENT_CNT_EN
    checks++;
    if (tick_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", tick_cnt);
    end
`endif
  endtask

  task automatic test_arm;
    bit ok;
    @(negedge clk);
    mtime = 64'h1000;
    period = 32'd100;
    wlog.delete();
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({psel, penable, pwrite, pstrb, paddr} !== {3'b100, 4'h0, Base + 32'h8}) begin
      errors++;
      $display("FAIL arm_setup: got %b_%h_%h want 100_0_%h", {psel, penable, pwrite}, pstrb, paddr, Base + 32'h8);
    end
    @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL arm_access: got %b want 11", {psel, penable});
    end
    wait_writes(3, 200, ok);
    if (ok) wait_idle(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL arm_timeout: got %0d writes want 3", wlog.size());
    end
    checks++;
    if (went(0) !== {4'hF, Base + 32'hC, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL arm_w0: got %h want %h", went(0), {4'hF, Base + 32'hC, 32'hFFFF_FFFF});
    end
    checks++;
    if (went(1) !== {4'hF, Base + 32'h10, 32'h0}) begin
      errors++;
      $display("FAIL arm_w1: got %h want %h", went(1), {4'hF, Base + 32'h10, 32'h0});
    end
    checks++;
    if (went(2) !== {4'hF, Base + 32'hC, 32'h1064}) begin
      errors++;
      $display("FAIL arm_w2: got %h want %h", went(2), {4'hF, Base + 32'hC, 32'h1064});
    end
  endtask

  task automatic test_boundary;
    bit ok;
    arm(64'h100, 32'd0, ok);
    checks++;
    if (went(2) !== {4'hF, Base + 32'hC, 32'h101}) begin
      errors++;
      $display("FAIL period_zero: got %h want cmpl 101", went(2));
    end
    arm(64'hFFFF_FFFF_FFFF_FFF0, 32'h20, ok);
    checks++;
    if ({went(1), went(2)} !== {4'hF, Base + 32'h10, 32'h0, 4'hF, Base + 32'hC, 32'h10}) begin
      errors++;
      $display("FAIL cmp_wrap: got %h %h want cmph 0 cmpl 10", went(1), went(2));
    end
  endtask

  task automatic test_carry;
    bit ok;
    int unsigned h0;
    carry_base = lreads;
    carry_mode = 1'b1;
    h0 = hreads;
    arm(64'hFFFF_FFF0, 32'd100, ok);
    carry_mode = 1'b0;
    checks++;
    if (hreads - h0 !== 4) begin
      errors++;
      $display("FAIL carry_reread: got %0d mtimeh reads want 4", hreads - h0);
    end
    checks++;
    if ({went(1), went(2)} !== {4'hF, Base + 32'h10, 32'h1, 4'hF, Base + 32'hC, 32'h74}) begin
      errors++;
      $display("FAIL carry_cmp: got %h %h want cmph 1 cmpl 74", went(1), went(2));
    end
  endtask

  task automatic test_periodic;
    bit ok;
    int unsigned t0;
    arm(64'h1000, 32'd50, ok);
    t0 = ticks;
    for (int k = 1; k <= 3; k++) begin
      wlog.delete();
      @(negedge clk);
      tmr = 1'b1;
      #1;
      checks++;
      if (tick !== 1'b1) begin
        errors++;
        $display("FAIL periodic_tick%0d: got %b want 1", k, tick);
      end
      @(negedge clk);
      tmr = 1'b0;
      wait_writes(3, 200, ok);
      if (ok) wait_idle(50, ok);
      checks++;
      if ({went(1), went(2)} !== {4'hF, Base + 32'h10, 32'h0, 4'hF, Base + 32'hC, 32'h1000 + 32'd50 * (k + 1)}) begin
        errors++;
        $display("FAIL periodic_cmp%0d: got %h %h want cmpl %h", k, went(1), went(2), 32'h1000 + 32'd50 * (k + 1));
      end
    end
    checks++;
    if (ticks - t0 !== 3) begin
      errors++;
      $display("FAIL periodic_count: got %0d want 3", ticks - t0);
    end
`ifdef CLINT_TICK_AGENT_CNT_EN
    checks++;
    if (tick_cnt !== 32'd3) begin
      errors++;
      $display("FAIL tick_cnt: got %0d want 3", tick_cnt);
    end
`endif
  endtask

  task automatic test_settle_catchup;
    bit ok;
    int unsigned t0, wc;
    arm(64'h4000, 32'd8, ok);
    wlog.delete();
    t0 = ticks;
    @(negedge clk);
    tmr = 1'b1;
    wait_writes(3, 200, ok);
    wc = ok ? wlog[2].cyc : 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ticks >= t0 + 2) begin
        ok = 1'b1;
        break;
      end
    end
    tmr = 1'b0;
    checks++;
    if (!ok || last_tick - wc !== 3) begin
      errors++;
      $display("FAIL settle_gap: got %0d cycles (seen %0d) want 3", last_tick - wc, ok);
    end
    wait_writes(6, 200, ok);
    if (ok) wait_idle(50, ok);
    checks++;
    if (went(5) !== {4'hF, Base + 32'hC, 32'h4018}) begin
      errors++;
      $display("FAIL catchup_cmp: got %h want cmpl 4018", went(5));
    end
  endtask

  task automatic test_sfr_timer;
    bit ok;
    int unsigned t0, a0;
    arm(64'h5000, 32'h10, ok);
    wlog.delete();
    t0 = ticks;
    a0 = acks;
    @(negedge clk);
    sfr = 1'b1;
    tmr = 1'b1;
    #1;
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL sfr_prio: got tick %b want 0", tick);
    end
    wait_writes(1, 50, ok);
    sfr = 1'b0;
    checks++;
    if (went(0) !== {4'hF, Base, 32'h0}) begin
      errors++;
      $display("FAIL msip_write: got %h want %h", went(0), {4'hF, Base, 32'h0});
    end
    checks++;
    if (acks - a0 !== 1) begin
      errors++;
      $display("FAIL sfr_ack: got %0d want 1", acks - a0);
    end
    wait_writes(2, 50, ok);
    tmr = 1'b0;
    wait_writes(4, 200, ok);
    if (ok) wait_idle(50, ok);
    checks++;
    if (ticks - t0 !== 1 || went(3) !== {4'hF, Base + 32'hC, 32'h5020}) begin
      errors++;
      $display("FAIL sfr_then_tmr: got ticks %0d w3 %h want 1 cmpl 5020", ticks - t0, went(3));
    end
  endtask

  task automatic test_pslverr;
    bit ok;
    @(negedge clk);
    en = 1'b0;
    err_inject = 1'b1;
    err_addr = Base + 32'h10;
    @(negedge clk);
    mtime = 64'h3000;
    period = 32'd8;
    wlog.delete();
    en = 1'b1;
    wait_writes(2, 100, ok);
    repeat (20) @(negedge clk);
    checks++;
    if ({err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL slverr_state: got err,busy %b want 10", {err, busy});
    end
    checks++;
    if (wlog.size() !== 2) begin
      errors++;
      $display("FAIL slverr_nocmpl: got %0d writes want 2", wlog.size());
    end
    err_inject = 1'b0;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL slverr_clear: got %b want 0", err);
    end
    arm(64'h3000, 32'd8, ok);
    checks++;
    if (!ok || went(2) !== {4'hF, Base + 32'hC, 32'h3008}) begin
      errors++;
      $display("FAIL slverr_rearm: got %h want cmpl 3008", went(2));
    end
  endtask

  task automatic test_en_low;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    wlog.delete();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL enlow_complete: got %b want 11", {psel, penable});
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({busy, psel} !== 2'b00 || wlog.size() !== 0) begin
      errors++;
      $display("FAIL enlow_stop: got busy,psel %b writes %0d want 00 0", {busy, psel}, wlog.size());
    end
  endtask

  task automatic test_wait_states;
    @(negedge clk);
    en = 1'b0;
    wait_n = 3;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({psel, penable, pready, paddr} !== {3'b110, Base + 32'h8}) begin
        errors++;
        $display("FAIL wait_hold%0d: got %b_%h want 110_%h", i, {psel, penable, pready}, paddr, Base + 32'h8);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable, busy, tick, sfr_ack, paddr} !== 37'h0) begin
      errors++;
      $display("FAIL reset_mid_access: got %b_%h want 0", {psel, penable, busy, tick, sfr_ack}, paddr);
    end
    en = 1'b0;
    wait_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arm();
    test_boundary();
    test_carry();
    test_periodic();
    test_settle_catchup();
    test_sfr_timer();
    test_pslverr();
    test_en_low();
    test_wait_states();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
